// File: rtl/calc_pkg.sv
// Shared encodings for the calculator core: commands, status codes, FSM states
// and seven-segment glyphs ({dp,g,f,e,d,c,b,a}, active high).
package calc_pkg;

   localparam logic [3:0] CMD_ADD = 4'hA;
   localparam logic [3:0] CMD_SUB = 4'hB;
   localparam logic [3:0] CMD_MUL = 4'hC;
   localparam logic [3:0] CMD_DIV = 4'hD;
   localparam logic [3:0] CMD_EQ  = 4'hE;
   localparam logic [3:0] CMD_CLR = 4'hF;

   localparam logic [1:0] STAT_ENTRY  = 2'b00;
   localparam logic [1:0] STAT_BUSY   = 2'b01;
   localparam logic [1:0] STAT_ERROR  = 2'b10;
   localparam logic [1:0] STAT_RESULT = 2'b11;

   typedef enum logic [2:0] {
      ST_ENTRY,
      ST_EXEC,
      ST_MUL,
      ST_CONV,
      ST_ERROR
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_DIV
   } op_e;

   localparam logic [7:0] SEG_MINUS = 8'h40;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   function automatic logic [7:0] seg_digit(input logic [3:0] d);
      case (d)
         4'd0:    return 8'h3F;
         4'd1:    return 8'h06;
         4'd2:    return 8'h5B;
         4'd3:    return 8'h4F;
         4'd4:    return 8'h66;
         4'd5:    return 8'h6D;
         4'd6:    return 8'h7D;
         4'd7:    return 8'h07;
         4'd8:    return 8'h7F;
         4'd9:    return 8'h6F;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble: converts a W-bit magnitude to NDIGITS BCD digits,
// one bit per cycle; done pulses for one cycle when bcd is valid.
module calc_bin2bcd
   import calc_pkg::*;
#(
   parameter int NDIGITS = 8,
   parameter int W       = 27
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [W-1:0]           bin,
   output logic                   done,
   output logic [NDIGITS*4-1:0]   bcd
);
   localparam int SW = NDIGITS * 4;
   localparam int KW = $clog2(W + 1);

   logic [W-1:0]  sh_q, sh_d;
   logic [SW-1:0] bcd_q, bcd_d, adj;
   logic [KW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   always_comb begin
      sh_d   = sh_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      adj    = bcd_q;
      for (int i = 0; i < NDIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
      // The first bit is taken on the start cycle itself; an all-zero BCD needs no correction.
      if (start) begin
         sh_d   = bin << 1;
         bcd_d  = SW'(bin[W-1]);
         cnt_d  = KW'(W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         sh_d  = sh_q << 1;
         bcd_d = {adj[SW-2:0], sh_q[W-1]};
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == KW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/calc_engine.sv
// Calculator core: decimal entry, add/sub/multiply (divide with CALC_DIV_EN),
// seven-segment display with sign, error and busy status.
//
// state    | meaning
// ENTRY    | accepting digits/operators; shows entry or last result
// EXEC     | one cycle: add/sub result, or set up the iterative datapath
// MUL      | W-cycle shift-add multiply or restoring divide
// CONV     | waiting for binary-to-BCD conversion, then display update
// ERROR    | overflow or divide by zero; only clear exits
module calc_engine
   import calc_pkg::*;
#(
   parameter int NDIGITS = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   input  logic [3:0]              cmd,
   output logic                    cmd_ready,
   output logic [NDIGITS-1:0][7:0] displays,
   output logic [1:0]              status
);
   localparam int W  = $clog2(10**NDIGITS);
   localparam int SW = NDIGITS * 4;
   localparam int CW = $clog2(NDIGITS + 1);
   localparam int KW = $clog2(W + 1);

   localparam logic [2*W-1:0] MAX_POS = (2*W)'(10**NDIGITS - 1);
   localparam logic [2*W-1:0] MAX_NEG = (2*W)'(10**(NDIGITS-1) - 1);
   localparam logic [CW-1:0]  NDIG    = CW'(NDIGITS);
   localparam logic [W-1:0]   TEN     = W'(10);
   localparam logic [NDIGITS-1:0][7:0] DISP_ZERO = (NDIGITS*8)'(8'h3F);
   localparam logic [NDIGITS-1:0][7:0] DISP_ERR  = (NDIGITS*8)'(SEG_E);

   state_e                   state_q, state_d;
   op_e                      op_q, op_d, nxt_op_q, nxt_op_d, new_op;
   logic                     pend_q, pend_d, chain_q, chain_d;
   logic                     a_neg_q, a_neg_d, res_neg_q, res_neg_d;
   logic [W-1:0]             a_mag_q, a_mag_d, acc_q, acc_d, res_mag_q, res_mag_d;
   logic [SW-1:0]            shadow_q, shadow_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     shown_q, shown_d, have_res_q, have_res_d;
   logic [2*W-1:0]           prod_q, prod_d, mcand_q, mcand_d;
   logic [W-1:0]             mplier_q, mplier_d;
   logic [KW-1:0]            step_q, step_d;
   logic                     start_q, start_d;
   logic [NDIGITS-1:0][7:0]  disp_q, disp_d;
   logic [1:0]               status_q, status_d;
   logic                     ready_q, ready_d;

   logic                     accept, is_op, clr_all, fin_en, fin_neg;
   logic [2*W-1:0]           fin_mag;
   logic signed [W+1:0]      a_val, b_val, sum;
   logic [W+1:0]             sum_mag;
   logic                     bcd_done;
   logic [SW-1:0]            bcd_val;
`ifdef CALC_DIV_EN
   logic [W:0]               rem_sh;
   logic                     qbit;
`endif

   // Leading zeros blank; the minus sign sits just left of the most significant digit.
   function automatic logic [NDIGITS-1:0][7:0] fmt(input logic [SW-1:0] bcd, input logic neg);
      logic [NDIGITS-1:0][7:0] r;
      int msd;
      r   = '0;
      msd = 0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) msd = i;
      end
      for (int i = 0; i < NDIGITS; i++) begin
         if (i <= msd) r[i] = seg_digit(bcd[i*4 +: 4]);
         else if (neg && i == msd + 1) r[i] = SEG_MINUS;
      end
      return r;
   endfunction

   calc_bin2bcd #(.NDIGITS(NDIGITS), .W(W)) u_bin2bcd (
      .clock (clock),
      .reset (reset),
      .start (start_q),
      .bin   (res_mag_q),
      .done  (bcd_done),
      .bcd   (bcd_val)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      nxt_op_d   = nxt_op_q;
      pend_d     = pend_q;
      chain_d    = chain_q;
      a_neg_d    = a_neg_q;
      a_mag_d    = a_mag_q;
      acc_d      = acc_q;
      shadow_d   = shadow_q;
      cnt_d      = cnt_q;
      res_neg_d  = res_neg_q;
      res_mag_d  = res_mag_q;
      shown_d    = shown_q;
      have_res_d = have_res_q;
      prod_d     = prod_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      step_d     = step_q;
      start_d    = 1'b0;
      disp_d     = disp_q;
      accept     = cmd_valid & ready_q;
      clr_all    = 1'b0;
      fin_en     = 1'b0;
      fin_neg    = 1'b0;
      fin_mag    = '0;
      a_val      = '0;
      b_val      = '0;
      sum        = '0;
      sum_mag    = '0;
`ifdef CALC_DIV_EN
      rem_sh     = '0;
      qbit       = 1'b0;
`endif
      is_op  = 1'b1;
      new_op = OP_ADD;
      case (cmd)
         CMD_ADD: new_op = OP_ADD;
         CMD_SUB: new_op = OP_SUB;
         CMD_MUL: new_op = OP_MUL;
`ifdef CALC_DIV_EN
         CMD_DIV: new_op = OP_DIV;
`endif
         default: is_op = 1'b0;
      endcase

      case (state_q)
         ST_ENTRY: begin
            if (accept) begin
               if (cmd < 4'd10) begin
                  if (shown_q) begin
                     acc_d    = W'(cmd);
                     shadow_d = SW'(cmd);
                     cnt_d    = CW'(1);
                     shown_d  = 1'b0;
                     disp_d   = fmt(shadow_d, 1'b0);
                  end else if (cnt_q < NDIG) begin
                     acc_d    = acc_q * TEN + W'(cmd);
                     shadow_d = {shadow_q[SW-5:0], cmd};
                     cnt_d    = cnt_q + 1'b1;
                     disp_d   = fmt(shadow_d, 1'b0);
                  end
               end else if (is_op) begin
                  if (pend_q && cnt_q == '0) begin
                     op_d = new_op;
                  end else if (pend_q) begin
                     state_d  = ST_EXEC;
                     chain_d  = 1'b1;
                     nxt_op_d = new_op;
                  end else begin
                     a_neg_d  = (cnt_q == '0) && have_res_q && res_neg_q;
                     a_mag_d  = (cnt_q != '0) ? acc_q : (have_res_q ? res_mag_q : '0);
                     op_d     = new_op;
                     pend_d   = 1'b1;
                     acc_d    = '0;
                     shadow_d = '0;
                     cnt_d    = '0;
                     shown_d  = 1'b0;
                  end
               end else if (cmd == CMD_EQ) begin
                  if (pend_q) begin
                     state_d = ST_EXEC;
                     chain_d = 1'b0;
                  end
               end else if (cmd == CMD_CLR) begin
                  clr_all = 1'b1;
               end
            end
         end

         ST_EXEC: begin
            case (op_q)
               OP_ADD, OP_SUB: begin
                  a_val = $signed({2'b00, a_mag_q});
                  if (a_neg_q) a_val = -a_val;
                  b_val   = $signed({2'b00, acc_q});
                  sum     = (op_q == OP_ADD) ? a_val + b_val : a_val - b_val;
                  sum_mag = sum[W+1] ? -sum : sum;
                  fin_en  = 1'b1;
                  fin_neg = sum[W+1];
                  fin_mag = (2*W)'(sum_mag);
               end
               OP_MUL: begin
                  prod_d   = '0;
                  mcand_d  = (2*W)'(a_mag_q);
                  mplier_d = acc_q;
                  step_d   = KW'(W);
                  state_d  = ST_MUL;
               end
`ifdef CALC_DIV_EN
               OP_DIV: begin
                  if (acc_q == '0) begin
                     state_d = ST_ERROR;
                     disp_d  = DISP_ERR;
                  end else begin
                     prod_d   = '0;
                     mplier_d = a_mag_q;
                     step_d   = KW'(W);
                     state_d  = ST_MUL;
                  end
               end
`endif
               default: begin
                  state_d = ST_ERROR;
                  disp_d  = DISP_ERR;
               end
            endcase
         end

         ST_MUL: begin
            step_d = step_q - 1'b1;
`ifdef CALC_DIV_EN
            // Restoring divide: remainder lives in prod_q, quotient shifts into mplier_q.
            if (op_q == OP_DIV) begin
               rem_sh = {prod_q[W-1:0], mplier_q[W-1]};
               if (rem_sh >= {1'b0, acc_q}) begin
                  rem_sh = rem_sh - {1'b0, acc_q};
                  qbit   = 1'b1;
               end
               prod_d   = (2*W)'(rem_sh);
               mplier_d = {mplier_q[W-2:0], qbit};
               fin_mag  = (2*W)'(mplier_d);
            end else begin
`else
            begin
`endif
               prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               fin_mag  = prod_d;
            end
            if (step_q == KW'(1)) begin
               fin_en  = 1'b1;
               fin_neg = a_neg_q && (fin_mag != '0);
            end
         end

         ST_CONV: begin
            if (bcd_done) begin
               disp_d     = fmt(bcd_val, res_neg_q);
               state_d    = ST_ENTRY;
               shown_d    = 1'b1;
               have_res_d = 1'b1;
               acc_d      = '0;
               shadow_d   = '0;
               cnt_d      = '0;
               chain_d    = 1'b0;
               pend_d     = chain_q;
               if (chain_q) begin
                  a_neg_d = res_neg_q;
                  a_mag_d = res_mag_q;
                  op_d    = nxt_op_q;
               end
            end
         end

         ST_ERROR: begin
            if (accept && cmd == CMD_CLR) clr_all = 1'b1;
         end

         default: begin
            state_d = ST_ERROR;
            disp_d  = DISP_ERR;
         end
      endcase

      if (fin_en) begin
         if (fin_neg ? (fin_mag > MAX_NEG) : (fin_mag > MAX_POS)) begin
            state_d = ST_ERROR;
            disp_d  = DISP_ERR;
         end else begin
            state_d   = ST_CONV;
            start_d   = 1'b1;
            res_neg_d = fin_neg;
            res_mag_d = fin_mag[W-1:0];
         end
      end

      if (clr_all) begin
         state_d    = ST_ENTRY;
         op_d       = OP_ADD;
         nxt_op_d   = OP_ADD;
         pend_d     = 1'b0;
         chain_d    = 1'b0;
         a_neg_d    = 1'b0;
         a_mag_d    = '0;
         acc_d      = '0;
         shadow_d   = '0;
         cnt_d      = '0;
         res_neg_d  = 1'b0;
         res_mag_d  = '0;
         shown_d    = 1'b0;
         have_res_d = 1'b0;
         disp_d     = DISP_ZERO;
      end

      ready_d = (state_d == ST_ENTRY) || (state_d == ST_ERROR);
      case (state_d)
         ST_ENTRY: status_d = shown_d ? STAT_RESULT : STAT_ENTRY;
         ST_ERROR: status_d = STAT_ERROR;
         default:  status_d = STAT_BUSY;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_ENTRY;
         op_q       <= OP_ADD;
         nxt_op_q   <= OP_ADD;
         pend_q     <= 1'b0;
         chain_q    <= 1'b0;
         a_neg_q    <= 1'b0;
         a_mag_q    <= '0;
         acc_q      <= '0;
         shadow_q   <= '0;
         cnt_q      <= '0;
         res_neg_q  <= 1'b0;
         res_mag_q  <= '0;
         shown_q    <= 1'b0;
         have_res_q <= 1'b0;
         prod_q     <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         step_q     <= '0;
         start_q    <= 1'b0;
         disp_q     <= DISP_ZERO;
         status_q   <= STAT_ENTRY;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         nxt_op_q   <= nxt_op_d;
         pend_q     <= pend_d;
         chain_q    <= chain_d;
         a_neg_q    <= a_neg_d;
         a_mag_q    <= a_mag_d;
         acc_q      <= acc_d;
         shadow_q   <= shadow_d;
         cnt_q      <= cnt_d;
         res_neg_q  <= res_neg_d;
         res_mag_q  <= res_mag_d;
         shown_q    <= shown_d;
         have_res_q <= have_res_d;
         prod_q     <= prod_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         step_q     <= step_d;
         start_q    <= start_d;
         disp_q     <= disp_d;
         status_q   <= status_d;
         ready_q    <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign displays  = disp_q;
   assign status    = status_q;

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine (NDIGITS=8); divide vectors run when CALC_DIV_EN is defined.
module tb_calc_engine;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           cmd_valid = 1'b0;
   logic [3:0]     cmd = 4'h0;
   logic           cmd_ready;
   logic [7:0][7:0] displays;
   logic [1:0]     status;

   int n_chk = 0;
   int n_err = 0;
   int lat;

   calc_engine #(.NDIGITS(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_ready (cmd_ready),
      .displays  (displays),
      .status    (status)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] c);
      int n;
      n = 0;
      while (!cmd_ready && n < 500) begin
         @(posedge clock); #1;
         n++;
      end
      if (!cmd_ready) check("send_ready_timeout", 64'(cmd_ready), 64'd1);
      cmd = c;
      cmd_valid = 1'b1;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic send_seq(input logic [3:0] seq[$]);
      foreach (seq[i]) send(seq[i]);
   endtask

   // Counts cycles with cmd_ready low, starting right after an accept edge.
   task automatic wait_ready(output int n);
      n = 0;
      while (!cmd_ready && n < 1000) begin
         n++;
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #2 reset = 1'b0;
      #3;
      check("rst_ready", 64'(cmd_ready), 64'd1);
      check("rst_status", 64'(status), 64'd0);
      check("rst_disp", displays, 64'h3F);
      repeat (2) @(posedge clock);
      #2 reset = 1'b1;
      @(posedge clock); #1;
      check("rel_ready", 64'(cmd_ready), 64'd1);
      check("rel_status", 64'(status), 64'd0);
      check("rel_disp", displays, 64'h3F);

      // 123 + 45 = 168
      send_seq('{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5});
      check("entry_45", displays, 64'h666D);
      send(4'hE);
      wait_ready(lat);
      check("add_latency", 64'(lat), 64'd29);
      check("add_disp", displays, 64'h067D7F);
      check("add_status", 64'(status), 64'd3);

      // 5 - 12 = -7, then -7 * 3 = -21 using the shown result as operand
      send(4'hF);
      send_seq('{4'h5, 4'hB, 4'h1, 4'h2, 4'hE});
      wait_ready(lat);
      check("sub_latency", 64'(lat), 64'd29);
      check("sub_disp", displays, 64'h4007);
      send_seq('{4'hC, 4'h3, 4'hE});
      wait_ready(lat);
      check("mul_latency", 64'(lat), 64'd56);
      check("mul_disp", displays, 64'h405B06);
      check("mul_status", 64'(status), 64'd3);

      // chaining: 2 + 3 + 4
      send(4'hF);
      send_seq('{4'h2, 4'hA, 4'h3, 4'hA});
      wait_ready(lat);
      check("chain_latency", 64'(lat), 64'd29);
      check("chain_mid_disp", displays, 64'h6D);
      send_seq('{4'h4, 4'hE});
      wait_ready(lat);
      check("chain_disp", displays, 64'h6F);

      // multiply overflow, ignored digit in ERROR, clear
      send(4'hF);
      send_seq('{4'h9, 4'h9, 4'h9, 4'h9, 4'hC, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hE});
      wait_ready(lat);
      check("movf_status", 64'(status), 64'd2);
      check("movf_disp", displays, 64'h79);
      send(4'h3);
      check("err_digit_disp", displays, 64'h79);
      check("err_digit_status", 64'(status), 64'd2);
      send(4'hF);
      check("clr_disp", displays, 64'h3F);
      check("clr_status", 64'(status), 64'd0);

      // entry length limit, then busy pulses are dropped
      send_seq('{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9});
      check("entry_limit_disp", displays, 64'h065B4F666D7D077F);
      check("entry_status", 64'(status), 64'd0);
      send_seq('{4'hA, 4'h1, 4'hE});
      for (int k = 0; k < 10; k++) begin
         cmd = 4'h5;
         cmd_valid = 1'b1;
         @(posedge clock); #1;
      end
      cmd_valid = 1'b0;
      wait_ready(lat);
      check("busy_drop_latency", 64'(lat + 10), 64'd29);
      check("busy_drop_disp", displays, 64'h065B4F666D7D076F);

      // positive boundary: 99999999 + 1 overflows
      send(4'hF);
      send_seq('{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hA, 4'h1, 4'hE});
      wait_ready(lat);
      check("aovf_status", 64'(status), 64'd2);

      // negative boundary: 0 - 9999999 fits, 0 - 10000000 does not
      send(4'hF);
      send_seq('{4'h0, 4'hB, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'hE});
      wait_ready(lat);
      check("neg_max_disp", displays, 64'h406F6F6F6F6F6F6F);
      check("neg_max_status", 64'(status), 64'd3);
      send(4'hF);
      send_seq('{4'h0, 4'hB, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE});
      wait_ready(lat);
      check("neg_ovf_status", 64'(status), 64'd2);

      // equals with nothing pending does nothing
      send(4'hF);
      send_seq('{4'h7, 4'hE});
      check("eq_noop_ready", 64'(cmd_ready), 64'd1);
      check("eq_noop_status", 64'(status), 64'd0);
      check("eq_noop_disp", displays, 64'h07);

`ifdef CALC_DIV_EN
      send(4'hF);
      send_seq('{4'h1, 4'h0, 4'h0, 4'hD, 4'h7, 4'hE});
      wait_ready(lat);
      check("div_latency", 64'(lat), 64'd56);
      check("div_disp", displays, 64'h0666);
      send(4'hF);
      send_seq('{4'h5, 4'hD, 4'h0, 4'hE});
      wait_ready(lat);
      check("div0_status", 64'(status), 64'd2);
`else
      send(4'hF);
      send_seq('{4'h5, 4'hD, 4'h3});
      check("div_ignored_disp", displays, 64'h6D4F);
      check("div_ignored_status", 64'(status), 64'd0);
`endif

      // reset asserted mid-computation aborts at once
      send(4'hF);
      send_seq('{4'h1, 4'hC, 4'h2, 4'hE});
      repeat (5) @(posedge clock);
      #1;
      check("busy_before_rst", 64'(status), 64'd1);
      reset = 1'b0;
      #1;
      check("abort_ready", 64'(cmd_ready), 64'd1);
      check("abort_status", 64'(status), 64'd0);
      check("abort_disp", displays, 64'h3F);
      @(posedge clock); #2;
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
